// File: rtl/sram_burst_ctrl_pkg.sv
// tron_mem_pkg -- shared constants and types for the SRAM burst sequencer.
//   Memory map of the 16-bit SRAM (word addresses):
//     two 640x480 frame buffers followed by a sprite table of 1 KiW slots.
//   sram_state_e : sequencer FSM states.
//   sprite_addr  : word address of sprite slot n.
package tron_mem_pkg;

    localparam logic [19:0] FRAME0_BASE   = 20'h00000;
    localparam logic [19:0] FRAME1_BASE   = 20'h4B000;
    localparam logic [19:0] FRAME_WORDS   = 20'h4B000;
    localparam logic [19:0] SPRITE_BASE   = 20'h96000;
    localparam logic [19:0] SPRITE_STRIDE = 20'h00400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_HOLD,
        S_WR_DATA,
        S_WR_PULSE,
        S_WR_REC,
        S_DONE
    } sram_state_e;

    function automatic logic [19:0] sprite_addr(input logic [7:0] n);
        return SPRITE_BASE + (20'(n) << 10);
    endfunction

endpackage

// File: rtl/sram_burst_ctrl_burst_counter.sv
// burst_counter -- word address / remaining-count registers of a burst.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   load_i          : take addr_i / len_i as a new burst
//   addr_i, len_i   : first word address and word count
//   step_i          : one word finished: address +1 (wraps), remaining -1
//   addr_o          : current word address
//   last_o          : the current word is the final one of the burst
module burst_counter #(
    parameter int ADDR_W = 20,
    parameter int LEN_W  = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    import tron_mem_pkg::*;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q,  rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = addr_i;
            rem_d  = len_i;
        end else if (step_i) begin
            // natural wrap at 2^ADDR_W; remaining count saturates at zero
            addr_d = addr_q + ADDR_W'(1);
            if (rem_q != '0)
                rem_d = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (rem_q == LEN_W'(1));

endmodule

// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl -- burst sequencer for a 16-bit asynchronous SRAM.
//   Command : cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_len (0 legal)
//   Read    : rd_data/rd_valid/rd_ready stream, one word per SRAM access
//   Write   : wr_data/wr_be/wr_valid/wr_ready stream
//   Status  : busy (not idle), done (one-cycle pulse per burst)
//   SRAM    : SRAM_ADDR, SRAM_CE_N/OE_N/WE_N/UB_N/LB_N, split DQ bus
//             (SRAM_DQ_I in, SRAM_DQ_O out, SRAM_DQ_OE drive enable)
//   Build option SRAM_BYTE_MASK_EN: wr_be gates UB_N/LB_N during the
//   write pulse; otherwise both byte lanes are always written.
//   All SRAM strobes are registered, decoded from the next state, so the
//   pins change glitch-free together with the FSM state.
module sram_burst_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 20,
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_be,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    input  logic [DATA_W-1:0] SRAM_DQ_I,
    output logic [DATA_W-1:0] SRAM_DQ_O,
    output logic              SRAM_DQ_OE
);
    import tron_mem_pkg::*;

    localparam int CNT_W = 8;

    sram_state_e       state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic [1:0]        be_q, be_d;
    logic              ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, dq_oe_q;
    logic              ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, dq_oe_d;

    logic              cnt_load, cnt_step, cnt_last;
    logic [ADDR_W-1:0] cnt_addr;

    burst_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_cnt (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .load_i (cnt_load),
        .addr_i (cmd_addr),
        .len_i  (cmd_len),
        .step_i (cnt_step),
        .addr_o (cnt_addr),
        .last_o (cnt_last)
    );

    // ---------------- next state ----------------
    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        dq_o_d     = dq_o_q;
        be_d       = be_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cnt_load = 1'b1;
                    if (cmd_len == '0)   state_d = S_DONE;
                    else if (cmd_write)  state_d = S_WR_DATA;
                    else                 state_d = S_RD_ADDR;
                end
            end
            // The first RD_ADDR cycle lets address and OE settle through the
            // pad registers; DQ is then sampled after RD_WAIT further cycles.
            S_RD_ADDR: begin
                if (wait_q == CNT_W'(RD_WAIT)) begin
                    rd_data_d  = SRAM_DQ_I;
                    rd_valid_d = 1'b1;
                    state_d    = S_RD_HOLD;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_RD_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    cnt_step   = 1'b1;
                    state_d    = cnt_last ? S_DONE : S_RD_ADDR;
                end
            end
            S_WR_DATA: begin
                if (wr_valid) begin
                    dq_o_d  = wr_data;
                    be_d    = wr_be;
                    state_d = S_WR_PULSE;
                end
            end
            S_WR_PULSE: begin
                if (wait_q == CNT_W'(WR_PULSE - 1))
                    state_d = S_WR_REC;
                else
                    wait_d = wait_q + CNT_W'(1);
            end
            // WE_N has risen; DQ keeps driving one cycle for data hold time
            S_WR_REC: begin
                cnt_step = 1'b1;
                state_d  = cnt_last ? S_DONE : S_WR_DATA;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- pin decode from next state ----------------
    always_comb begin
        ce_n_d  = (state_d == S_IDLE) || (state_d == S_DONE);
        oe_n_d  = (state_d != S_RD_ADDR);
        we_n_d  = (state_d != S_WR_PULSE);
        dq_oe_d = (state_d == S_WR_PULSE) || (state_d == S_WR_REC);
        ub_n_d  = ce_n_d;
        lb_n_d  = ce_n_d;
`ifdef SRAM_BYTE_MASK_EN
        if (state_d == S_WR_PULSE) begin
            ub_n_d = ~be_d[1];
            lb_n_d = ~be_d[0];
        end
`endif
    end

`ifndef SRAM_BYTE_MASK_EN
    // byte enables are latched but have no effect in this build
    logic unused_be;
    assign unused_be = ^be_q;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            dq_o_q     <= '0;
            be_q       <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            dq_o_q     <= dq_o_d;
            be_q       <= be_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign wr_ready   = (state_q == S_WR_DATA);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign SRAM_ADDR  = cnt_addr;
    assign SRAM_CE_N  = ce_n_q;
    assign SRAM_OE_N  = oe_n_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_UB_N  = ub_n_q;
    assign SRAM_LB_N  = lb_n_q;
    assign SRAM_DQ_O  = dq_o_q;
    assign SRAM_DQ_OE = dq_oe_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb_sram_burst_ctrl -- directed bench for sram_burst_ctrl.
//   Reads see DQ = addr[15:0] ^ 16'hA5A5; writes land in a sparse model.
module tb_sram_burst_ctrl;

    localparam int RD_WAIT  = 1;
    localparam int WR_PULSE = 1;

    logic        Clk, Reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [19:0] cmd_addr, cmd_len;
    logic [15:0] rd_data, wr_data;
    logic        rd_valid, rd_ready;
    logic [1:0]  wr_be;
    logic        wr_valid, wr_ready, busy, done;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic [15:0] SRAM_DQ_I, SRAM_DQ_O;
    logic        SRAM_DQ_OE;

    sram_burst_ctrl #(
        .ADDR_W(20), .DATA_W(16), .LEN_W(20), .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_be(wr_be), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .done(done),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_DQ_I(SRAM_DQ_I), .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign SRAM_DQ_I = SRAM_ADDR[15:0] ^ 16'hA5A5;

    // ---------------- monitors ----------------
    logic [15:0] mem [logic [19:0]];
    logic [15:0] rdq[$];
    logic [19:0] addrq[$];
    int          done_cnt, we_cyc, we_pulses, viol;
    logic        we_prev_n;
    logic [1:0]  last_ublb;

    initial begin
        done_cnt = 0; we_cyc = 0; we_pulses = 0; viol = 0;
        we_prev_n = 1'b1; last_ublb = 2'b11;
    end

    always @(posedge Clk) begin
        if (rd_valid && rd_ready) begin
            rdq.push_back(rd_data);
            addrq.push_back(SRAM_ADDR);
        end
        if (done) done_cnt++;
        if (SRAM_DQ_OE && !SRAM_OE_N) viol++;
        if (!SRAM_WE_N) begin
            we_cyc++;
            if (we_prev_n) we_pulses++;
            last_ublb = {SRAM_UB_N, SRAM_LB_N};
            if (!SRAM_CE_N && SRAM_DQ_OE) mem[SRAM_ADDR] = SRAM_DQ_O;
        end
        we_prev_n = SRAM_WE_N;
    end

    // ---------------- check helpers ----------------
    int n_assert, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [19:0] a, input logic [19:0] l);
        cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = 20'hDEAD0;
        cmd_len   = 20'h7;
        cmd_write = ~wr;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin ok = 1; break; end
            step();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic write_word(input logic [15:0] d, input logic [1:0] be);
        int n;
        wr_valid = 1'b0;
        step(); step();
        wr_data = d; wr_be = be; wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 50) begin step(); n++; end
        chk("wr_ready_seen", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic mem_chk(input string tag, input logic [19:0] a, input logic [15:0] exp);
        logic [15:0] v;
        v = mem.exists(a) ? mem[a] : 16'hxxxx;
        chk(tag, 32'(v), 32'(exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, base, d0, we0, pu0;
        n_assert = 0; n_fail = 0;
        Reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        rd_ready = 0; wr_data = 0; wr_be = 2'b11; wr_valid = 0;

        // 1: reset state
        #12;
        chk("rst_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        chk("rst_dq_oe",   32'(SRAM_DQ_OE), 32'd0);
        chk("rst_status",  32'({rd_valid, busy, cmd_ready, wr_ready, done}), 32'b00100);
        chk("rst_addr",    32'(SRAM_ADDR), 32'd0);
        chk("rst_data",    32'({rd_data, SRAM_DQ_O}), 32'd0);
        step();
        Reset = 1'b0;
        step();

        // 2: read 0x4B000 len 4, consumer always ready
        rd_ready = 1'b1;
        d0 = done_cnt;
        issue(1'b0, 20'h4B000, 20'd4);
        chk("rd_busy", 32'({busy, cmd_ready, SRAM_CE_N, SRAM_OE_N}), 32'b1000);
        n = 0;
        while (!rd_valid && n < 20) begin step(); n++; end
        chk("rd_first_latency", 32'(n), 32'(RD_WAIT + 1));
        wait_done("rd_done");
        step(); step();
        chk("rd_words", 32'(rdq.size()), 32'd4);
        if (rdq.size() == 4) begin
            chk("rd_w0", 32'(rdq[0]), 32'h15A5);
            chk("rd_w1", 32'(rdq[1]), 32'h15A4);
            chk("rd_w2", 32'(rdq[2]), 32'h15A7);
            chk("rd_w3", 32'(rdq[3]), 32'h15A6);
        end
        chk("rd_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("rd_idle_strobes", 32'({SRAM_CE_N, SRAM_OE_N, busy}), 32'b110);

        // 3: same read, consumer stalls on word 2
        base = rdq.size();
        issue(1'b0, 20'h4B000, 20'd4);
        n = 0;
        while (rdq.size() < base + 1 && n < 50) begin step(); n++; end
        rd_ready = 1'b0;
        n = 0;
        while (!rd_valid && n < 20) begin step(); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", 32'({rd_valid, rd_data}), 32'h115A4);
            chk("stall_addr", 32'(SRAM_ADDR), 32'h4B001);
            step();
        end
        rd_ready = 1'b1;
        wait_done("stall_done");
        step();
        chk("stall_words", 32'(rdq.size() - base), 32'd4);
        if (rdq.size() == base + 4) begin
            chk("stall_w1", 32'(rdq[base+1]), 32'h15A4);
            chk("stall_w2", 32'(rdq[base+2]), 32'h15A7);
            chk("stall_w3", 32'(rdq[base+3]), 32'h15A6);
        end

        // 4: write 0x96400 len 3 with 2-cycle wr_valid gaps
        we0 = we_cyc; pu0 = we_pulses;
        issue(1'b1, 20'h96400, 20'd3);
        write_word(16'h1111, 2'b11);
        write_word(16'h2222, 2'b11);
        write_word(16'h3333, 2'b11);
        wait_done("wr_done");
        step();
        mem_chk("wr_m0", 20'h96400, 16'h1111);
        mem_chk("wr_m1", 20'h96401, 16'h2222);
        mem_chk("wr_m2", 20'h96402, 16'h3333);
        chk("wr_we_cycles", 32'(we_cyc - we0), 32'(3 * WR_PULSE));
        chk("wr_we_pulses", 32'(we_pulses - pu0), 32'd3);
        chk("wr_addr_end", 32'(SRAM_ADDR), 32'h96403);

        // 5: address wrap and zero-length burst
        base = rdq.size();
        issue(1'b0, 20'hFFFFF, 20'd2);
        wait_done("wrap_done");
        step();
        chk("wrap_words", 32'(rdq.size() - base), 32'd2);
        if (rdq.size() == base + 2) begin
            chk("wrap_a0", 32'(addrq[base]),   32'hFFFFF);
            chk("wrap_a1", 32'(addrq[base+1]), 32'h00000);
            chk("wrap_d0", 32'(rdq[base]),     32'h5A5A);
            chk("wrap_d1", 32'(rdq[base+1]),   32'hA5A5);
        end
        d0 = done_cnt;
        issue(1'b0, 20'h12345, 20'd0);
        chk("len0_done", 32'({done, busy, cmd_ready, SRAM_CE_N}), 32'b1101);
        step();
        chk("len0_idle", 32'({done, busy, cmd_ready, SRAM_CE_N}), 32'b0011);
        chk("len0_pulses", 32'(done_cnt - d0), 32'd1);

        // 6: byte enables on a single write
        issue(1'b1, 20'h96000, 20'd1);
        write_word(16'hBEEF, 2'b01);
        wait_done("be_done");
`ifdef SRAM_BYTE_MASK_EN
        chk("be_ublb", 32'(last_ublb), 32'b10);
`else
        chk("be_ublb", 32'(last_ublb), 32'b00);
`endif
        mem_chk("be_mem", 20'h96000, 16'hBEEF);
        chk("dq_oe_vs_oe", 32'(viol), 32'd0);
        step();

        // 1b: reset pulse in the middle of a write pulse
        issue(1'b1, 20'h4B010, 20'd1);
        wr_data = 16'h5555; wr_be = 2'b11; wr_valid = 1'b1;
        n = 0;
        while (SRAM_WE_N && n < 20) begin step(); n++; end
        chk("mid_we_low", 32'(SRAM_WE_N), 32'd0);
        Reset = 1'b1;
        #1;
        chk("mid_rst_pins", 32'({SRAM_WE_N, SRAM_CE_N, SRAM_DQ_OE}), 32'b110);
        chk("mid_rst_state", 32'({busy, cmd_ready, wr_ready}), 32'b010);
        wr_valid = 1'b0;
        #2 Reset = 1'b0;
        step();
        chk("mid_rst_idle", 32'({busy, SRAM_WE_N}), 32'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
